// File: rtl/bp_update_arbiter_pkg.sv
// Shared types and constants for the branch-predictor update arbiter.
// Provides default `SIZE_PC / `BRANCH_TYPE_LOG widths when the wider build does not.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE_LOG
`define BRANCH_TYPE_LOG 2
`endif

package bp_update_arbiter_pkg;

    localparam int unsigned PC_W = `SIZE_PC;
    localparam int unsigned BT_W = `BRANCH_TYPE_LOG;

    // Only conditional branches carry a meaningful saturating counter.
    localparam logic [BT_W-1:0] CTRL_COND_BRANCH = '0;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] npc;
        logic [BT_W-1:0] ctrlType;
        logic            dir;
        logic [1:0]      counter;
    } bpUpdPkt;

    typedef enum logic {
        SRC_FS2 = 1'b0,
        SRC_EXE = 1'b1
    } bpUpdSrc_e;

    function automatic logic isCondBranch(input logic [BT_W-1:0] ctrl_type);
        return ctrl_type == CTRL_COND_BRANCH;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small circular queue of predictor updates; full requests are dropped and
// flush clears the queue, both taking priority over push/pop.
module bp_update_fifo
    import bp_update_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  logic    i_pop,
    input  logic    i_flush,
    input  bpUpdPkt i_data,
    output bpUpdPkt o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    bpUpdPkt          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bp_update_arbiter.sv
// Merges fetch-2 and execute predictor updates onto one table write port:
// execute priority with a starvation limit. Optional BP_UPDATE_ARB_STATS_EN adds drop/starve counters.
module bp_update_arbiter
    import bp_update_arbiter_pkg::*;
#(
    parameter int unsigned FS2_Q_DEPTH  = 4,
    parameter int unsigned EXE_Q_DEPTH  = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            fs2UpdEn_i,
    input  logic [PC_W-1:0] fs2UpdPC_i,
    input  logic [PC_W-1:0] fs2UpdNPC_i,
    input  logic [BT_W-1:0] fs2UpdType_i,
    input  logic            fs2UpdDir_i,
    input  logic [1:0]      fs2UpdCounter_i,
    output logic            fs2QFull_o,
    input  logic            exeUpdEn_i,
    input  logic [PC_W-1:0] exeUpdPC_i,
    input  logic [PC_W-1:0] exeUpdNPC_i,
    input  logic [BT_W-1:0] exeUpdType_i,
    input  logic            exeUpdDir_i,
    input  logic [1:0]      exeUpdCounter_i,
    output logic            exeQFull_o,
    input  logic            tableBusy_i,
    output logic            wrEn_o,
    output logic [PC_W-1:0] wrPC_o,
    output logic [PC_W-1:0] wrNPC_o,
    output logic [BT_W-1:0] wrType_o,
    output logic            wrDir_o,
    output logic [1:0]      wrCounter_o,
    output logic            wrCtrEn_o,
    output logic            wrSrc_o
`ifdef BP_UPDATE_ARB_STATS_EN
    ,
    output logic [15:0]     fs2DropCnt_o,
    output logic [15:0]     exeDropCnt_o,
    output logic [15:0]     starveGrantCnt_o
`endif
);

    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    bpUpdPkt          w_fs2_in;
    bpUpdPkt          w_exe_in;
    bpUpdPkt          w_fs2_head;
    bpUpdPkt          w_exe_head;
    bpUpdPkt          w_grant_pkt;
    logic             w_fs2_full;
    logic             w_fs2_empty;
    logic             w_exe_full;
    logic             w_exe_empty;
    logic             w_arb_en;
    logic             w_fs2_pend;
    logic             w_exe_pend;
    logic             w_grant_exe;
    logic             w_grant_fs2;
    logic             w_grant;

    bpUpdPkt          r_wr_pkt;
    logic             r_wr_en;
    logic             r_ctr_en;
    bpUpdSrc_e        r_wr_src;
    logic [STV_W-1:0] r_starve_cnt;

    assign w_fs2_in = '{pc: fs2UpdPC_i, npc: fs2UpdNPC_i, ctrlType: fs2UpdType_i,
                        dir: fs2UpdDir_i, counter: fs2UpdCounter_i};
    assign w_exe_in = '{pc: exeUpdPC_i, npc: exeUpdNPC_i, ctrlType: exeUpdType_i,
                        dir: exeUpdDir_i, counter: exeUpdCounter_i};

    bp_update_fifo #(.DEPTH(FS2_Q_DEPTH)) u_fs2_q (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (fs2UpdEn_i),
        .i_pop   (w_grant_fs2),
        .i_flush (flush_i),
        .i_data  (w_fs2_in),
        .o_head  (w_fs2_head),
        .o_full  (w_fs2_full),
        .o_empty (w_fs2_empty)
    );

    bp_update_fifo #(.DEPTH(EXE_Q_DEPTH)) u_exe_q (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (exeUpdEn_i),
        .i_pop   (w_grant_exe),
        .i_flush (1'b0),
        .i_data  (w_exe_in),
        .o_head  (w_exe_head),
        .o_full  (w_exe_full),
        .o_empty (w_exe_empty)
    );

    assign w_arb_en    = !(r_wr_en && tableBusy_i);
    // A flushing fs2 queue counts as empty so none of its entries can win this cycle.
    assign w_fs2_pend  = !w_fs2_empty && !flush_i;
    assign w_exe_pend  = !w_exe_empty;
    assign w_grant_exe = w_arb_en && w_exe_pend && (r_starve_cnt < STARVE_MAX);
    assign w_grant_fs2 = w_arb_en && !w_grant_exe && w_fs2_pend;
    assign w_grant     = w_grant_exe || w_grant_fs2;
    assign w_grant_pkt = w_grant_exe ? w_exe_head : w_fs2_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (flush_i) begin
            r_starve_cnt <= '0;
        end else if (w_arb_en) begin
            if (w_grant_fs2 || !w_fs2_pend)
                r_starve_cnt <= '0;
            else if (w_grant_exe && r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + STV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en  <= 1'b0;
            r_ctr_en <= 1'b0;
            r_wr_src <= SRC_FS2;
            r_wr_pkt <= '0;
        end else if (w_arb_en) begin
            r_wr_en  <= w_grant;
            r_ctr_en <= w_grant && isCondBranch(w_grant_pkt.ctrlType);
            if (w_grant) begin
                r_wr_pkt <= w_grant_pkt;
                r_wr_src <= w_grant_exe ? SRC_EXE : SRC_FS2;
            end
        end
    end

    assign fs2QFull_o  = w_fs2_full;
    assign exeQFull_o  = w_exe_full;
    assign wrEn_o      = r_wr_en;
    assign wrPC_o      = r_wr_pkt.pc;
    assign wrNPC_o     = r_wr_pkt.npc;
    assign wrType_o    = r_wr_pkt.ctrlType;
    assign wrDir_o     = r_wr_pkt.dir;
    assign wrCounter_o = r_wr_pkt.counter;
    assign wrCtrEn_o   = r_ctr_en;
    assign wrSrc_o     = r_wr_src;

`ifdef BP_UPDATE_ARB_STATS_EN
    logic [15:0] r_fs2_drop;
    logic [15:0] r_exe_drop;
    logic [15:0] r_starve_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fs2_drop     <= '0;
            r_exe_drop     <= '0;
            r_starve_grant <= '0;
        end else begin
            if (fs2UpdEn_i && (w_fs2_full || flush_i) && r_fs2_drop != '1)
                r_fs2_drop <= r_fs2_drop + 16'd1;
            if (exeUpdEn_i && w_exe_full && r_exe_drop != '1)
                r_exe_drop <= r_exe_drop + 16'd1;
            // An fs2 grant with exe still pending can only come from the starvation limit.
            if (w_grant_fs2 && w_exe_pend && r_starve_grant != '1)
                r_starve_grant <= r_starve_grant + 16'd1;
        end
    end

    assign fs2DropCnt_o     = r_fs2_drop;
    assign exeDropCnt_o     = r_exe_drop;
    assign starveGrantCnt_o = r_starve_grant;
`endif

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Self-checking bench for bp_update_arbiter: directed vector table, hand sequences
// for starvation/full/flush/reset, and randomized traffic against a queue-based model.
module tb_bp_update_arbiter;
    import bp_update_arbiter_pkg::*;

    localparam int unsigned D2  = 4;
    localparam int unsigned DE  = 4;
    localparam int unsigned LIM = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush_i = 1'b0;
    logic            fs2UpdEn_i = 1'b0;
    logic [PC_W-1:0] fs2UpdPC_i = '0;
    logic [PC_W-1:0] fs2UpdNPC_i = '0;
    logic [BT_W-1:0] fs2UpdType_i = '0;
    logic            fs2UpdDir_i = 1'b0;
    logic [1:0]      fs2UpdCounter_i = '0;
    logic            fs2QFull_o;
    logic            exeUpdEn_i = 1'b0;
    logic [PC_W-1:0] exeUpdPC_i = '0;
    logic [PC_W-1:0] exeUpdNPC_i = '0;
    logic [BT_W-1:0] exeUpdType_i = '0;
    logic            exeUpdDir_i = 1'b0;
    logic [1:0]      exeUpdCounter_i = '0;
    logic            exeQFull_o;
    logic            tableBusy_i = 1'b0;
    logic            wrEn_o;
    logic [PC_W-1:0] wrPC_o;
    logic [PC_W-1:0] wrNPC_o;
    logic [BT_W-1:0] wrType_o;
    logic            wrDir_o;
    logic [1:0]      wrCounter_o;
    logic            wrCtrEn_o;
    logic            wrSrc_o;
`ifdef BP_UPDATE_ARB_STATS_EN
    logic [15:0]     fs2DropCnt_o;
    logic [15:0]     exeDropCnt_o;
    logic [15:0]     starveGrantCnt_o;
`endif

    always #5 clk = ~clk;

    bp_update_arbiter #(
        .FS2_Q_DEPTH  (D2),
        .EXE_Q_DEPTH  (DE),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush_i         (flush_i),
        .fs2UpdEn_i      (fs2UpdEn_i),
        .fs2UpdPC_i      (fs2UpdPC_i),
        .fs2UpdNPC_i     (fs2UpdNPC_i),
        .fs2UpdType_i    (fs2UpdType_i),
        .fs2UpdDir_i     (fs2UpdDir_i),
        .fs2UpdCounter_i (fs2UpdCounter_i),
        .fs2QFull_o      (fs2QFull_o),
        .exeUpdEn_i      (exeUpdEn_i),
        .exeUpdPC_i      (exeUpdPC_i),
        .exeUpdNPC_i     (exeUpdNPC_i),
        .exeUpdType_i    (exeUpdType_i),
        .exeUpdDir_i     (exeUpdDir_i),
        .exeUpdCounter_i (exeUpdCounter_i),
        .exeQFull_o      (exeQFull_o),
        .tableBusy_i     (tableBusy_i),
        .wrEn_o          (wrEn_o),
        .wrPC_o          (wrPC_o),
        .wrNPC_o         (wrNPC_o),
        .wrType_o        (wrType_o),
        .wrDir_o         (wrDir_o),
        .wrCounter_o     (wrCounter_o),
        .wrCtrEn_o       (wrCtrEn_o),
        .wrSrc_o         (wrSrc_o)
`ifdef BP_UPDATE_ARB_STATS_EN
        ,
        .fs2DropCnt_o     (fs2DropCnt_o),
        .exeDropCnt_o     (exeDropCnt_o),
        .starveGrantCnt_o (starveGrantCnt_o)
`endif
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two FIFOs of packets, an exe-streak counter and the visible write.
    bpUpdPkt     mq2[$];
    bpUpdPkt     mqe[$];
    int unsigned m_streak;
    bit          m_wr_en;
    bit          m_src;
    bit          m_ctr_en;
    bpUpdPkt     m_out;

    function automatic void model_reset();
        mq2.delete();
        mqe.delete();
        m_streak = 0;
        m_wr_en  = 0;
        m_src    = 0;
        m_ctr_en = 0;
        m_out    = '0;
    endfunction

    function automatic void model_step();
        bpUpdPkt p2, pe;
        bit free, fs2_wait, g_exe, g_fs2, acc2, acce;
        if (!reset_n) begin
            model_reset();
            return;
        end
        p2.pc = fs2UpdPC_i; p2.npc = fs2UpdNPC_i; p2.ctrlType = fs2UpdType_i;
        p2.dir = fs2UpdDir_i; p2.counter = fs2UpdCounter_i;
        pe.pc = exeUpdPC_i; pe.npc = exeUpdNPC_i; pe.ctrlType = exeUpdType_i;
        pe.dir = exeUpdDir_i; pe.counter = exeUpdCounter_i;
        free     = !(m_wr_en && tableBusy_i);
        fs2_wait = (mq2.size() != 0) && !flush_i;
        g_exe    = free && (mqe.size() != 0) && (m_streak < LIM);
        g_fs2    = free && !g_exe && fs2_wait;
        acc2     = fs2UpdEn_i && (mq2.size() < D2) && !flush_i;
        acce     = exeUpdEn_i && (mqe.size() < DE);
        if (free) begin
            m_wr_en  = g_exe || g_fs2;
            m_ctr_en = 0;
            if (g_exe) begin
                m_out = mqe.pop_front();
                m_src = 1;
            end else if (g_fs2) begin
                m_out = mq2.pop_front();
                m_src = 0;
            end
            if (m_wr_en) m_ctr_en = (m_out.ctrlType == CTRL_COND_BRANCH);
            if (g_fs2 || !fs2_wait) m_streak = 0;
            else if (g_exe) m_streak++;
        end
        if (flush_i) begin
            mq2.delete();
            m_streak = 0;
        end
        if (acc2) mq2.push_back(p2);
        if (acce) mqe.push_back(pe);
    endfunction

    task automatic check_model();
        chk("m_wrEn", wrEn_o, m_wr_en);
        chk("m_ctrEn", wrCtrEn_o, m_ctr_en);
        chk("m_fs2Full", fs2QFull_o, mq2.size() == D2);
        chk("m_exeFull", exeQFull_o, mqe.size() == DE);
        if (m_wr_en) begin
            chk("m_pc", wrPC_o, m_out.pc);
            chk("m_npc", wrNPC_o, m_out.npc);
            chk("m_type", wrType_o, m_out.ctrlType);
            chk("m_dir", wrDir_o, m_out.dir);
            chk("m_ctr", wrCounter_o, m_out.counter);
            chk("m_src", wrSrc_o, m_src);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    task automatic drive(input bit e2, input logic [PC_W-1:0] p2, input bit ee,
                         input logic [PC_W-1:0] pe, input bit busy, input bit fl);
        fs2UpdEn_i = e2; fs2UpdPC_i = p2; fs2UpdNPC_i = p2 + PC_W'(4);
        fs2UpdType_i = CTRL_COND_BRANCH; fs2UpdDir_i = 1'b1; fs2UpdCounter_i = 2'b10;
        exeUpdEn_i = ee; exeUpdPC_i = pe; exeUpdNPC_i = pe + PC_W'(8);
        exeUpdType_i = '1; exeUpdDir_i = 1'b0; exeUpdCounter_i = 2'b01;
        tableBusy_i = busy; flush_i = fl;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wrEn"}, wrEn_o, 0);
        chk({tag, "_pc"}, wrPC_o, 0);
        chk({tag, "_npc"}, wrNPC_o, 0);
        chk({tag, "_type"}, wrType_o, 0);
        chk({tag, "_dir"}, wrDir_o, 0);
        chk({tag, "_ctr"}, wrCounter_o, 0);
        chk({tag, "_ctrEn"}, wrCtrEn_o, 0);
        chk({tag, "_src"}, wrSrc_o, 0);
        chk({tag, "_fs2Full"}, fs2QFull_o, 0);
        chk({tag, "_exeFull"}, exeQFull_o, 0);
    endtask

    typedef struct {
        bit              en2;
        logic [PC_W-1:0] pc2;
        bit              ene;
        logic [PC_W-1:0] pce;
        bit              busy;
        bit              exp_en;
        logic [PC_W-1:0] exp_pc;
        bit              exp_src;
    } vec_t;

    vec_t tv[10];

    initial begin
        bit [0:5]        ord;
        logic [PC_W-1:0] rp;
        model_reset();

        // Reset state
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;

        // Latency, table-busy hold, then drain
        tv[0] = '{1, 'h1000, 0, 'h0,    0, 0, 'h0,    0};
        tv[1] = '{0, 'h0,    0, 'h0,    0, 1, 'h1000, 0};
        tv[2] = '{0, 'h0,    0, 'h0,    0, 0, 'h0,    0};
        tv[3] = '{0, 'h0,    1, 'h2000, 0, 0, 'h0,    0};
        tv[4] = '{0, 'h0,    0, 'h0,    1, 1, 'h2000, 1};
        tv[5] = '{1, 'h1100, 0, 'h0,    1, 1, 'h2000, 1};
        tv[6] = '{0, 'h0,    0, 'h0,    1, 1, 'h2000, 1};
        tv[7] = '{0, 'h0,    0, 'h0,    1, 1, 'h2000, 1};
        tv[8] = '{0, 'h0,    0, 'h0,    0, 1, 'h1100, 0};
        tv[9] = '{0, 'h0,    0, 'h0,    0, 0, 'h0,    0};
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].en2, tv[i].pc2, tv[i].ene, tv[i].pce, tv[i].busy, 0);
            tick();
            chk($sformatf("tv%0d_wrEn", i), wrEn_o, tv[i].exp_en);
            chk($sformatf("tv%0d_ctrEn", i), wrCtrEn_o, tv[i].exp_en && !tv[i].exp_src);
            if (tv[i].exp_en) begin
                chk($sformatf("tv%0d_pc", i), wrPC_o, tv[i].exp_pc);
                chk($sformatf("tv%0d_src", i), wrSrc_o, tv[i].exp_src);
            end
        end

        // Starvation: exe,exe,exe,fs2,exe,exe
        ord = 6'b111011;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 'h4000, i < 8, PC_W'('h3000 + i), 0, 0);
            tick();
            if (i >= 1 && i <= 6) begin
                chk($sformatf("starve%0d_en", i), wrEn_o, 1);
                chk($sformatf("starve%0d_src", i), wrSrc_o, ord[i-1]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("starve_drained", wrEn_o, 0);

        // Full queue under busy: 5th request dropped, 4 writes in order
        drive(0, 0, 1, 'h5100, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        chk("full_hold_pc", wrPC_o, 'h5100);
        for (int k = 0; k < 5; k++) begin
            drive(1, PC_W'('h5000 + k), 0, 0, 1, 0);
            tick();
            if (k == 2) chk("full_before", fs2QFull_o, 0);
            if (k >= 3) chk($sformatf("full_after%0d", k), fs2QFull_o, 1);
        end
`ifdef BP_UPDATE_ARB_STATS_EN
        chk("fs2DropCnt", fs2DropCnt_o, 1);
`endif
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("full_wr%0d_en", k), wrEn_o, 1);
            chk($sformatf("full_wr%0d_pc", k), wrPC_o, PC_W'('h5000 + k));
            chk($sformatf("full_wr%0d_src", k), wrSrc_o, 0);
        end
        tick();
        chk("full_no5th", wrEn_o, 0);

        // Flush drops queued fs2, keeps exe and the in-register write
        drive(0, 0, 1, 'h6000, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1, PC_W'('h7000 + k), 1, PC_W'('h6001 + k), 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 1);
        tick();
        chk("flush_reg_pc", wrPC_o, 'h6000);
        chk("flush_reg_en", wrEn_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("flush_wr%0d_en", k), wrEn_o, 1);
            chk($sformatf("flush_wr%0d_pc", k), wrPC_o, PC_W'('h6001 + k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("flush_none%0d", k), wrEn_o, 0);
        end

        // Randomized traffic with a mid-stream asynchronous reset
        for (int c = 0; c < 400; c++) begin
            fs2UpdEn_i      = ($urandom_range(0, 9) < 6);
            fs2UpdPC_i      = PC_W'($urandom);
            fs2UpdNPC_i     = PC_W'($urandom);
            fs2UpdType_i    = BT_W'($urandom);
            fs2UpdDir_i     = 1'($urandom);
            fs2UpdCounter_i = 2'($urandom);
            exeUpdEn_i      = ($urandom_range(0, 9) < 6);
            exeUpdPC_i      = PC_W'($urandom);
            exeUpdNPC_i     = PC_W'($urandom);
            exeUpdType_i    = BT_W'($urandom);
            exeUpdDir_i     = 1'($urandom);
            exeUpdCounter_i = 2'($urandom);
            tableBusy_i     = ($urandom_range(0, 9) < 3);
            flush_i         = ($urandom_range(0, 99) < 4);
            if (c == 200) begin
                #3;
                reset_n = 1'b0;
                #1;
                model_reset();
                chk_all_zero("midreset");
                tick();
                chk_all_zero("midreset_hold");
                reset_n = 1'b1;
                drive(0, 0, 0, 0, 0, 0);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk($sformatf("postreset%0d", k), wrEn_o, 0);
                end
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
